// File: rtl/piso_tx.sv
// Parallel-in serial-out transmitter: serializes a WIDTH-bit word MSB first with sof/done framing.
// Latency: first serial bit on dout one cycle after the accepting edge; all outputs registered (Moore).
// Backpressure: din_ready high only when idle or on the final bit of a frame; the source holds din until accepted.
//
// Ports: clk, rst (sync, active-low); din/din_valid/din_ready parallel input handshake;
//        dout/dout_valid serial output, sof on first bit, done pulse on last bit.
// Optional feature macro: PISO_PARITY_EN appends an even-parity bit (PAR state) to each frame.
module piso_tx #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             dout,
  output logic             dout_valid,
  output logic             sof,
  output logic             done
);

  localparam int CW = $clog2(WIDTH);

`ifdef PISO_PARITY_EN
  typedef enum logic [1:0] {IDLE, SHIFT, PAR} state_t;
`else
  typedef enum logic [1:0] {IDLE, SHIFT} state_t;
`endif

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sr_q, sr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             dout_q, dout_d;
  logic             vld_q, vld_d;
  logic             sof_q, sof_d;
  logic             done_q, done_d;
  logic             rdy_q, rdy_d;
`ifdef PISO_PARITY_EN
  logic             par_q, par_d;
`endif

  logic take;     // accept din at this edge
  logic go_idle;  // frame ends with nothing to follow
  logic last_bit;

  assign last_bit = (cnt_q == CW'(WIDTH - 1));

  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    cnt_d   = cnt_q;
    dout_d  = dout_q;
    vld_d   = vld_q;
    sof_d   = sof_q;
    done_d  = done_q;
    rdy_d   = rdy_q;
`ifdef PISO_PARITY_EN
    par_d   = par_q;
`endif
    take    = 1'b0;
    go_idle = 1'b0;

    case (state_q)
      IDLE: begin
        take    = din_valid;
      end
      SHIFT: begin
        if (last_bit) begin
`ifdef PISO_PARITY_EN
          // Last data bit: the parity bit follows, so no handoff yet.
          state_d = PAR;
          sr_d    = sr_q << 1;
          dout_d  = par_q;
          vld_d   = 1'b1;
          sof_d   = 1'b0;
          done_d  = 1'b1;
          rdy_d   = 1'b1;
`else
          take    = din_valid;
          go_idle = ~din_valid;
`endif
        end else begin
          sr_d    = sr_q << 1;
          cnt_d   = cnt_q + CW'(1);
          // Registered output is the bit that becomes MSB after this shift.
          dout_d  = sr_q[WIDTH-2];
          vld_d   = 1'b1;
          sof_d   = 1'b0;
`ifdef PISO_PARITY_EN
          done_d  = 1'b0;
          rdy_d   = 1'b0;
`else
          done_d  = ((cnt_q + CW'(1)) == CW'(WIDTH - 1));
          rdy_d   = ((cnt_q + CW'(1)) == CW'(WIDTH - 1));
`endif
        end
      end
`ifdef PISO_PARITY_EN
      PAR: begin
        take    = din_valid;
        go_idle = ~din_valid;
      end
`endif
      default: begin
        go_idle = 1'b1;
      end
    endcase

    if (take) begin
      state_d = SHIFT;
      sr_d    = din;
      cnt_d   = '0;
      dout_d  = din[WIDTH-1];
      vld_d   = 1'b1;
      sof_d   = 1'b1;
      done_d  = 1'b0;
      rdy_d   = 1'b0;  // WIDTH >= 2, so the first bit is never the last
`ifdef PISO_PARITY_EN
      par_d   = ^din;
`endif
    end else if (go_idle) begin
      state_d = IDLE;
      sr_d    = '0;
      cnt_d   = '0;
      dout_d  = 1'b0;
      vld_d   = 1'b0;
      sof_d   = 1'b0;
      done_d  = 1'b0;
      rdy_d   = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      sr_q    <= '0;
      cnt_q   <= '0;
      dout_q  <= 1'b0;
      vld_q   <= 1'b0;
      sof_q   <= 1'b0;
      done_q  <= 1'b0;
      rdy_q   <= 1'b1;  // gated by rst below, so it shows only after release
`ifdef PISO_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      cnt_q   <= cnt_d;
      dout_q  <= dout_d;
      vld_q   <= vld_d;
      sof_q   <= sof_d;
      done_q  <= done_d;
      rdy_q   <= rdy_d;
`ifdef PISO_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  assign din_ready  = rst & rdy_q;
  assign dout       = dout_q;
  assign dout_valid = vld_q;
  assign sof        = sof_q;
  assign done       = done_q;

endmodule

// File: doc/piso_tx.md
PISO_TX -- requirements
Module: piso_tx

Interface
REQ-001 Parameter: WIDTH, default 4, number of data bits per frame (legal range 2..32).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-low (asserted when 0).
REQ-004 din  input  WIDTH  parallel word to serialize.
REQ-005 din_valid  input  1  din holds a word offered for transfer.
REQ-006 din_ready  output  1  block can accept a word this cycle.
REQ-007 dout  output  1  serial data, MSB first.
REQ-008 dout_valid  output  1  dout carries a frame bit this cycle.
REQ-009 sof  output  1  high on the first serial bit of each frame.
REQ-010 done  output  1  one-cycle pulse on the last serial bit of each frame.

Function
REQ-011 The block SHALL implement states IDLE and SHIFT, plus PAR when PISO_PARITY_EN is defined.
REQ-012 The block SHALL accept a word on a rising edge where din_valid=1 and din_ready=1; no other edge loads din.
REQ-013 din_ready SHALL be 1 in IDLE and during the last serial bit cycle of a frame, and 0 otherwise.
REQ-014 On acceptance, the block SHALL load din into a WIDTH-bit shift register, clear the bit counter, and enter SHIFT.
REQ-015 Latency SHALL be one cycle: the first bit (din[WIDTH-1]) appears on dout in the cycle after the accepting edge.
REQ-016 In SHIFT, dout SHALL equal shift register MSB; each edge shifts left by one with 0 fill and increments the counter.
REQ-017 Outputs SHALL depend only on registered state (Moore); din/din_valid SHALL NOT combinationally affect dout, dout_valid, sof or done.
REQ-018 dout_valid SHALL be 1 in SHIFT and PAR, else 0; dout SHALL be 0 whenever dout_valid=0.
REQ-019 sof SHALL be 1 only when counter=0 in SHIFT.
REQ-020 Without parity, done SHALL pulse when counter=WIDTH-1 in SHIFT; with parity, done SHALL pulse in PAR only.
REQ-021 At the end of a frame, acceptance on the last-bit edge SHALL start the next frame with no gap (dout_valid stays 1); no acceptance SHALL return to IDLE.
REQ-022 din_valid while din_ready=0 SHALL be ignored; the source must hold the word until accepted.
REQ-023 The counter SHALL be clog2(WIDTH) bits wide and SHALL never wrap within a frame.

Reset
REQ-024 While rst=0 on a rising edge, the state SHALL become IDLE, shift register and counter SHALL become 0.
REQ-025 After reset: dout=0, dout_valid=0, sof=0, done=0; din_ready SHALL be forced 0 while rst=0 and become 1 in the first cycle after release.
REQ-026 Reset mid-frame SHALL abort the frame: no done pulse, remaining bits discarded, the word is not retransmitted.

Configuration
REQ-027 Macro PISO_PARITY_EN: when defined, a PAR state SHALL follow the last data bit and drive dout = XOR of the frame's WIDTH data bits (even parity), giving WIDTH+1 bits per frame; din_ready is then high in PAR instead of the last data bit.
REQ-028 Without PISO_PARITY_EN, no PAR state or parity logic SHALL exist; frames are exactly WIDTH bits.

Verification (WIDTH=4)
REQ-029 Reset: rst=0 for 3 cycles mid-traffic -> dout, dout_valid, sof, done, din_ready all 0; din_ready=1 in the first cycle after release.
REQ-030 Single word: 4'b1011 accepted at edge N -> dout 1,0,1,1 in cycles N+1..N+4; sof at N+1; done and din_ready at N+4; dout_valid=0 at N+5.
REQ-031 Back-to-back: 4'hA, then 4'h5 held valid -> 8 contiguous bits 1,0,1,0,0,1,0,1; dout_valid never drops; sof on bits 1 and 5; done on bits 4 and 8.
REQ-032 Busy ignore: din=4'hF, din_valid=1 during bits 1-3 of frame 4'h0 -> din_ready=0; frame stays 0,0,0,0; 4'hF accepted on the bit-4 edge.
REQ-033 Reset mid-frame: rst=0 after bit 2 of 4'hC -> dout_valid=0 next cycle, no done pulse.
REQ-034 With PISO_PARITY_EN: 4'b0111 -> dout 0,1,1,1,1 over 5 cycles; done and din_ready only on the 5th (parity) bit.
